// File: rtl/store_serializer.sv
// store_serializer: turns one SB/SH/SW store request into consecutive
// little-endian byte writes on the 8-bit RAM write port, then pulses done.
module store_serializer #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        ORDER_W  = 6,
   parameter logic [ORDER_W-1:0] ORDER_SB = ORDER_W'(20),
   parameter logic [ORDER_W-1:0] ORDER_SH = ORDER_W'(21),
   parameter logic [ORDER_W-1:0] ORDER_SW = ORDER_W'(22)
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               rdy_in,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ORDER_W-1:0] req_order,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [31:0]        req_data,
   output logic [ADDR_W-1:0]  mem_a,
   output logic [7:0]         mem_dout,
   output logic               mem_wr,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
   logic [31:0]         data_q, data_d;
   logic [1:0]          k_q, k_d;
   logic [1:0]          last_q, last_d;

   logic                is_store;
   logic [1:0]          req_last;

   // Decode the order code into "is a store" and index of its final byte.
   always_comb begin
      is_store = 1'b1;
      req_last = 2'd0;
      if (req_order == ORDER_SB) begin
         req_last = 2'd0;
      end else if (req_order == ORDER_SH) begin
         req_last = 2'd1;
      end else if (req_order == ORDER_SW) begin
         req_last = 2'd3;
      end else begin
         is_store = 1'b0;
      end
   end

   // Next-state and datapath update; everything holds while rdy_in is low.
   // The address register steps by one per byte and the data register shifts
   // right by a byte, so the low byte is always the one on the port.
   always_comb begin
      state_d = state_q;
      mem_a_d = mem_a_q;
      data_d  = data_q;
      k_d     = k_q;
      last_d  = last_q;
      if (rdy_in) begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (is_store) begin
                     state_d = WRITE;
                     mem_a_d = req_addr;
                     data_d  = req_data;
                     k_d     = 2'd0;
                     last_d  = req_last;
                  end else begin
                     state_d = FINISH;
                  end
               end
            end
            WRITE: begin
               if (k_q == last_q) begin
                  state_d = FINISH;
               end else begin
                  k_d     = k_q + 2'd1;
                  mem_a_d = mem_a_q + ADDR_W'(1);
                  data_d  = data_q >> 8;
               end
            end
            FINISH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mem_a_q <= '0;
         data_q  <= '0;
         k_q     <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         mem_a_q <= mem_a_d;
         data_q  <= data_d;
         k_q     <= k_d;
         last_q  <= last_d;
      end
   end

   // Output decode; strobes are gated by rdy_in so a paused cycle never writes
   // and the done pulse lands on exactly one enabled cycle.
   always_comb begin
      req_ready = (state_q == IDLE);
      busy      = (state_q == WRITE);
      mem_wr    = (state_q == WRITE) && rdy_in;
      done      = (state_q == FINISH) && rdy_in;
      mem_a     = mem_a_q;
      mem_dout  = data_q[7:0];
   end

endmodule

// File: tb/tb_store_serializer.sv
// Bench for store_serializer: table of store requests, a scoreboard of
// expected byte writes, and hand-written reset-abort sequence.
module tb_store_serializer;

   localparam logic [5:0] O_SB = 6'd20;
   localparam logic [5:0] O_SH = 6'd21;
   localparam logic [5:0] O_SW = 6'd22;
   localparam logic [5:0] O_LW = 6'd17;

   logic        clk_in = 1'b0;
   logic        rst_n;
   logic        rdy_in;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_order;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;
   wr_t sb[$];

   typedef struct {
      logic [5:0]  order;
      logic [31:0] addr;
      logic [31:0] data;
      int          nb;
      int          pstart;
      int          plen;
      bit          junk;
      int          exp_done;
      int          exp_ready;
   } vec_t;
   vec_t vecs[8];

   store_serializer #(
      .ADDR_W(32),
      .ORDER_W(6),
      .ORDER_SB(O_SB),
      .ORDER_SH(O_SH),
      .ORDER_SW(O_SW)
   ) dut (
      .clk_in(clk_in),
      .rst_n(rst_n),
      .rdy_in(rdy_in),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_order(req_order),
      .req_addr(req_addr),
      .req_data(req_data),
      .mem_a(mem_a),
      .mem_dout(mem_dout),
      .mem_wr(mem_wr),
      .busy(busy),
      .done(done)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every strobed write must match the oldest outstanding expected byte.
   always @(negedge clk_in) begin
      if (rst_n === 1'b1 && mem_wr === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", mem_a, e.a);
            chk("wr_byte", {24'd0, mem_dout}, {24'd0, e.d});
         end
      end
   end

   // Issue one request starting just after a rising edge, then walk it cycle
   // by cycle against a small reference model of the serializer.
   task automatic run_vec(input vec_t v);
      int  st;   // 0 idle, 1 write, 2 finish
      int  k;
      int  done_c;
      int  ready_c;
      bit  en;
      logic [31:0] av;
      logic [31:0] dv;
      av = v.addr;
      dv = v.data;
      for (int i = 0; i < v.nb; i++) begin
         wr_t e;
         e.a = av + i;
         e.d = dv[8*i +: 8];
         sb.push_back(e);
      end
      rdy_in    = 1'b1;
      req_valid = 1'b1;
      req_order = v.order;
      req_addr  = v.addr;
      req_data  = v.data;
      @(negedge clk_in);
      chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk_in);
      #1;
      req_order = O_SB;
      req_addr  = $urandom;
      req_data  = $urandom;
      st = (v.nb == 0) ? 2 : 1;
      k = 0;
      done_c = 0;
      ready_c = 0;
      for (int c = 1; c <= 20 && ready_c == 0; c++) begin
         en = !(c >= v.pstart && c < v.pstart + v.plen);
         rdy_in    = en;
         req_valid = v.junk && (c < v.exp_ready);
         @(negedge clk_in);
         chk("mem_wr",    {31'd0, mem_wr},    {31'd0, (st == 1) && en});
         chk("busy",      {31'd0, busy},      {31'd0, st == 1});
         chk("done",      {31'd0, done},      {31'd0, (st == 2) && en});
         chk("req_ready", {31'd0, req_ready}, {31'd0, st == 0});
         if (st == 1) begin
            chk("held_addr", mem_a, av + k);
            chk("held_byte", {24'd0, mem_dout}, {24'd0, dv[8*k +: 8]});
         end
         if (done === 1'b1 && done_c == 0) done_c = c;
         if (req_ready === 1'b1) ready_c = c;
         if (en) begin
            if (st == 1) begin
               if (k == v.nb - 1) st = 2;
               else k++;
            end else if (st == 2) begin
               st = 0;
            end
         end
         @(posedge clk_in);
         #1;
      end
      req_valid = 1'b0;
      rdy_in    = 1'b1;
      chk("done_cycle",  done_c,  v.exp_done);
      chk("ready_cycle", ready_c, v.exp_ready);
      chk("sb_drained",  sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      vecs[0] = '{O_SW, 32'h0000_1000, 32'hDEAD_BEEF, 4, 0, 0, 1'b0, 5, 6};
      vecs[1] = '{O_SB, 32'h0000_0007, 32'h1234_5678, 1, 0, 0, 1'b0, 2, 3};
      vecs[2] = '{O_SH, 32'hFFFF_FFFF, 32'h0000_A55A, 2, 0, 0, 1'b0, 3, 4};
      vecs[3] = '{O_SW, 32'h0000_2001, 32'hCAFE_F00D, 4, 2, 3, 1'b0, 8, 9};
      vecs[4] = '{O_LW, 32'h0000_4444, 32'h5555_5555, 0, 0, 0, 1'b0, 1, 2};
      vecs[5] = '{O_SW, 32'h0000_3FFE, 32'h1122_3344, 4, 0, 0, 1'b1, 5, 6};
      vecs[6] = '{O_SH, 32'h0000_0FFF, 32'h0000_BEEF, 2, 0, 0, 1'b0, 3, 4};
      vecs[7] = '{O_SB, 32'h0000_0100, 32'h0000_0099, 1, 2, 2, 1'b0, 4, 5};

      rst_n     = 1'b0;
      rdy_in    = 1'b1;
      req_valid = 1'b0;
      req_order = '0;
      req_addr  = '0;
      req_data  = '0;
      #2;
      chk("rst_ready",  {31'd0, req_ready}, 32'd1);
      chk("rst_busy",   {31'd0, busy},      32'd0);
      chk("rst_done",   {31'd0, done},      32'd0);
      chk("rst_wr",     {31'd0, mem_wr},    32'd0);
      chk("rst_addr",   mem_a,              32'd0);
      chk("rst_dout",   {24'd0, mem_dout},  32'd0);
      repeat (2) @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      @(posedge clk_in);
      #1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset asserted while byte 2 of a word store is on the port.
      for (int i = 0; i < 4; i++) begin
         wr_t e;
         logic [31:0] d;
         d = 32'h8765_4321;
         e.a = 32'h0000_5000 + i;
         e.d = d[8*i +: 8];
         sb.push_back(e);
      end
      req_valid = 1'b1;
      req_order = O_SW;
      req_addr  = 32'h0000_5000;
      req_data  = 32'h8765_4321;
      @(posedge clk_in);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("pre_rst_addr", mem_a, 32'h0000_5002);
      chk("pre_rst_wr",   {31'd0, mem_wr}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_wr",    {31'd0, mem_wr},    32'd0);
      chk("abort_busy",  {31'd0, busy},      32'd0);
      chk("abort_done",  {31'd0, done},      32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_addr",  mem_a,              32'd0);
      chk("abort_dout",  {24'd0, mem_dout},  32'd0);
      chk("abort_left",  sb.size(),          2);
      sb.delete();
      @(negedge clk_in);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      @(negedge clk_in);
      chk("after_rst_done",  {31'd0, done},      32'd0);
      chk("after_rst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk_in);
      #1;
      run_vec(vecs[1]);

      repeat (3) @(posedge clk_in);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
